// File: rtl/sd_pkg.sv
// Shared sigma-delta definitions: bit-to-level mapping, internal width, clip bounds.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package sd_pkg;

  // Level carried by each bitstream symbol: 1 -> +1, 0 -> -1.
  localparam int SD_BIT_ONE  = 1;
  localparam int SD_BIT_ZERO = -1;

  // Internal CIC word width for a sinc2 filter with decimation ratio 2^osr_log2.
  function automatic int calc_w(input int osr_log2);
    return 2 * osr_log2 + 2;
  endfunction

  // Largest representable output level: 2^(2L) - 1.
  function automatic longint sat_hi(input int osr_log2);
    return (64'sd1 <<< (2 * osr_log2)) - 64'sd1;
  endfunction

  // Smallest representable output level: -2^(2L).
  function automatic longint sat_lo(input int osr_log2);
    return -(64'sd1 <<< (2 * osr_log2));
  endfunction

endpackage

// File: rtl/sd_decimator_if.sv
// Bitstream-in / decimated-word-out bundle of the sigma-delta decimator.
// Latency: none (wires only).
// Backpressure: none; bs_en qualifies input bits, dout_valid qualifies output words.
interface sd_decimator_if #(
  parameter int OUTWIDTH = 16
);
  logic                       bs_en;
  logic                       bs_in;
  logic signed [OUTWIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       sat;

  modport master (output bs_en, bs_in, input dout, dout_valid, sat);
  modport slave  (input bs_en, bs_in, output dout, dout_valid, sat);
endinterface

// File: rtl/sd_cic2_comb.sv
// Sinc2 comb differentiator, clip to the (2L+1)-bit range and output truncation.
// Latency: 1 cycle from dec_strobe to dout/dout_valid.
// Backpressure: none; runs on every dec_strobe, dout holds between updates.
module sd_cic2_comb
  import sd_pkg::*;
#(
  parameter int OSR_LOG2 = 8,
  parameter int OUTWIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             dec_strobe,
  input  logic                             warm_done,
  input  logic [calc_w(OSR_LOG2)-1:0]      int2,
  output logic signed [OUTWIDTH-1:0]       dout,
  output logic                             dout_valid,
  output logic                             sat
);
  localparam int W     = calc_w(OSR_LOG2);
  localparam int L2    = 2 * OSR_LOG2;
  localparam int SHIFT = L2 + 1 - OUTWIDTH;
  localparam logic signed [W-1:0] SAT_HI = W'(sat_hi(OSR_LOG2));
  localparam logic signed [W-1:0] SAT_LO = W'(sat_lo(OSR_LOG2));

  logic [W-1:0]        int2_d;
  logic [W-1:0]        c1_d;
  logic [W-1:0]        c1;
  logic [W-1:0]        c2;
  logic signed [W-1:0] c2_s;
  logic                clip_hi;
  logic                clip_lo;
  logic [L2:0]         fmt;

  // Two differentiators (mod 2^W) followed by clipping into the (2L+1)-bit range.
  always_comb begin
    c1      = int2 - int2_d;
    c2      = c1 - c1_d;
    c2_s    = signed'(c2);
    clip_hi = (c2_s > SAT_HI);
    clip_lo = (c2_s < SAT_LO);
    fmt     = c2[L2:0];
    if (clip_hi) begin
      fmt = SAT_HI[L2:0];
    end else if (clip_lo) begin
      fmt = SAT_LO[L2:0];
    end
  end

  // Advance comb delays and publish the top OUTWIDTH bits on each decimation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int2_d     <= '0;
      c1_d       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sat        <= 1'b0;
      if (dec_strobe) begin
        int2_d     <= int2;
        c1_d       <= c1;
        dout       <= OUTWIDTH'(fmt >> SHIFT);
        dout_valid <= warm_done;
        sat        <= warm_done & (clip_hi | clip_lo);
      end
    end
  end

endmodule

// File: rtl/sd_decimator.sv
// Recovers a signed word from a 1-bit sigma-delta stream with a sinc2 CIC, ratio 2^OSR_LOG2.
// Latency: dout_valid one cycle after dec_strobe, i.e. two edges counting the R-th bit's edge.
// Backpressure: none; bs_en gaps simply pause integration, outputs never stall.
module sd_decimator
  import sd_pkg::*;
#(
  parameter int OSR_LOG2 = 8,
  parameter int OUTWIDTH = 16,
  parameter int WARMUP   = 2
) (
  input logic          clk,
  input logic          reset,
  sd_decimator_if.slave bus
);
  localparam int W = calc_w(OSR_LOG2);

  logic [W-1:0]               x;
  logic [W-1:0]               int1;
  logic [W-1:0]               int2;
  logic [W-1:0]               int1_next;
  logic [W-1:0]               int2_next;
  logic [OSR_LOG2-1:0]        cnt;
  logic                       dec_strobe;
  logic [1:0]                 warm_cnt;
  logic                       warm_done;
  logic signed [OUTWIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       sat;

  // Map the incoming bit to +/-1 and chain both integrators in one cycle.
  always_comb begin
    x         = bus.bs_in ? W'(SD_BIT_ONE) : W'(SD_BIT_ZERO);
    int1_next = int1 + x;
    int2_next = int2 + int1_next;
  end

  assign warm_done = (warm_cnt == 2'(WARMUP));

  // Integrate accepted bits and flag every R-th one; wraparound is intended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int1       <= '0;
      int2       <= '0;
      cnt        <= '0;
      dec_strobe <= 1'b0;
    end else begin
      dec_strobe <= 1'b0;
      if (bus.bs_en) begin
        int1       <= int1_next;
        int2       <= int2_next;
        cnt        <= cnt + 1'b1;
        dec_strobe <= (cnt == '1);
      end
    end
  end

  // Count decimations until the filter has flushed its start-up transient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (dec_strobe && !warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  sd_cic2_comb #(
    .OSR_LOG2 (OSR_LOG2),
    .OUTWIDTH (OUTWIDTH)
  ) u_comb (
    .clk        (clk),
    .reset      (reset),
    .dec_strobe (dec_strobe),
    .warm_done  (warm_done),
    .int2       (int2),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat        (sat)
  );

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.sat        = sat;

endmodule

// File: tb/tb_sd_decimator.sv
// Bench for sd_decimator: directed and random bitstreams against a sinc2 FIR reference.
// Reference convolves the last 2R accepted levels with the triangular sinc2 kernel.
// Output words are expected one edge after the edge that accepted each R-th bit.
module tb_sd_decimator;
  localparam int OSR_LOG2 = 8;
  localparam int OUTWIDTH = 16;
  localparam int WARMUP   = 2;
  localparam int R        = 1 << OSR_LOG2;
  localparam int SHIFT    = 2 * OSR_LOG2 + 1 - OUTWIDTH;
  localparam longint HI   = (64'sd1 <<< (2 * OSR_LOG2)) - 1;
  localparam longint LO   = -(64'sd1 <<< (2 * OSR_LOG2));

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sd_decimator_if #(.OUTWIDTH(OUTWIDTH)) bus ();

  sd_decimator #(
    .OSR_LOG2 (OSR_LOG2),
    .OUTWIDTH (OUTWIDTH),
    .WARMUP   (WARMUP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     hist[$];
  int     acc;
  int     ndec;
  int     nvalid;
  logic   pend;
  int     pend_dout;
  logic   pend_valid;
  logic   pend_sat;
  int     exp_dout;
  logic   exp_valid;
  logic   exp_sat;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decimation: triangular sinc2 kernel over the last 2R levels, clip, truncate.
  task automatic model_decim();
    longint s;
    int     n;
    int     w;
    s = 0;
    n = hist.size();
    for (int j = 0; j < 2 * R && j < n; j++) begin
      w = (j < R) ? (j + 1) : (2 * R - 1 - j);
      s += longint'(w * hist[n - 1 - j]);
    end
    pend_sat = 1'b0;
    if (s > HI) begin
      s = HI;
      pend_sat = 1'b1;
    end else if (s < LO) begin
      s = LO;
      pend_sat = 1'b1;
    end
    pend_dout  = int'(s >>> SHIFT);
    pend_valid = (ndec > WARMUP);
    pend_sat   = pend_sat & pend_valid;
  endtask

  task automatic step(input logic en, input logic b);
    bus.bs_en = en;
    bus.bs_in = b;
    @(posedge clk);
    #1;
    if (pend) begin
      exp_dout  = pend_dout;
      exp_valid = pend_valid;
      exp_sat   = pend_sat;
    end else begin
      exp_valid = 1'b0;
      exp_sat   = 1'b0;
    end
    chk("dout_valid", bus.dout_valid, exp_valid);
    chk("dout", bus.dout, exp_dout);
    chk("sat", bus.sat, exp_sat);
    if (exp_valid) nvalid++;
    pend = 1'b0;
    if (en) begin
      hist.push_back(b ? 1 : -1);
      if (hist.size() > 2 * R) void'(hist.pop_front());
      acc++;
      if (acc % R == 0) begin
        ndec++;
        model_decim();
        pend = 1'b1;
      end
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge arrives.
  task automatic do_reset();
    bus.bs_en = 1'b0;
    bus.bs_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_sat", bus.sat, 0);
    hist.delete();
    acc = 0; ndec = 0; nvalid = 0;
    pend = 1'b0; exp_dout = 0; exp_valid = 1'b0; exp_sat = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    bus.bs_en = 1'b0;
    bus.bs_in = 1'b0;

    // Full-scale positive: clipped to 0x7FFF with sat.
    do_reset();
    for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ones_dout", bus.dout, 32767);
    chk("ones_count", nvalid, 4);

    // Full-scale negative: exactly representable, no clip.
    do_reset();
    for (int i = 0; i < 5 * R; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("zeros_dout", bus.dout, -32768);
    chk("zeros_count", nvalid, 3);

    // Alternating bits average to zero.
    do_reset();
    for (int i = 0; i < 5 * R; i++) step(1'b1, i[0] ? 1'b0 : 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("alt_dout", bus.dout, 0);

    // 1,1,1,0 averages to +0.5 of full scale.
    do_reset();
    for (int i = 0; i < 5 * R; i++) step(1'b1, (i % 4 != 3));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pat1110_dout", bus.dout, 16384);

    // Random bs_en gaps with constant ones.
    do_reset();
    for (int i = 0; i < 20 * R && acc < 5 * R; i++) step(1'($urandom_range(0, 1)), 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("gap_accepted", acc, 5 * R);
    chk("gap_dout", bus.dout, 32767);
    chk("gap_count", nvalid, 3);

    // Random bits with random gaps against the FIR reference.
    do_reset();
    for (int i = 0; i < 20 * R && acc < 6 * R; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rand_count", nvalid, ndec - WARMUP);

    // Reset in the middle of the third frame, then a clean run.
    do_reset();
    for (int i = 0; i < 2 * R + R / 2; i++) step(1'b1, 1'b1);
    chk("pre_rst_dout", bus.dout, 32767);
    do_reset();
    for (int i = 0; i < 5 * R; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("post_rst_dout", bus.dout, 32767);
    chk("post_rst_count", nvalid, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
